// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Brief    : Round-robin arbiter and glitch-free reconfiguration sequencer for
//            a programmable clock divider shared by two requesters.
//            Optional statistics counters: define CLK_DIV_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_sched #(
    parameter int RATIO_W    = 4,
    parameter int DEF_RATIO  = 5,
    parameter int SETTLE_CYC = 4,
    parameter int WRAP_TMO   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [RATIO_W-1:0] req0_ratio,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [RATIO_W-1:0] req1_ratio,
    output logic               req1_ready,
    input  logic               div_wrap,
    output logic               div_en,
    output logic [RATIO_W-1:0] div_ratio,
    output logic               div_load,
    output logic               busy,
    output logic               err,
`ifdef CLK_DIV_SCHED_STATS_EN
    output logic [15:0]        reconfig_cnt,
    output logic [7:0]         reject_cnt,
`endif
    output logic               tmo
);

    localparam int c_CNT_MAX = (WRAP_TMO > SETTLE_CYC) ? WRAP_TMO : SETTLE_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST    = c_CNT_W'(WRAP_TMO - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [RATIO_W-1:0] c_DEF_RATIO   = RATIO_W'(DEF_RATIO);
    localparam logic [RATIO_W-1:0] c_MIN_RATIO   = RATIO_W'(2);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_ARB       = 3'd2,
        S_WAIT_WRAP = 3'd3,
        S_GATE      = 3'd4,
        S_SETTLE    = 3'd5,
        S_ENABLE    = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_prio;      // 1: req1 wins a tie
    logic [RATIO_W-1:0]   r_cap;
    logic                 r_ready0;
    logic                 r_ready1;
    logic                 r_err;
    logic                 r_div_en;
    logic [RATIO_W-1:0]   r_div_ratio;
    logic                 r_div_load;
    logic                 r_busy;
    logic                 r_tmo;

    logic                 w_any;
    logic                 w_win1;
    logic [RATIO_W-1:0]   w_win_ratio;
    logic                 w_win_bad;
    logic                 w_grant;
    logic                 w_to_gate;

    assign w_any       = req0_valid | req1_valid;
    assign w_win1      = req1_valid & (~req0_valid | r_prio);
    assign w_win_ratio = w_win1 ? req1_ratio : req0_ratio;
    assign w_win_bad   = (w_win_ratio < c_MIN_RATIO);
    assign w_grant     = (r_state == S_IDLE) && w_any;
    assign w_to_gate   = (r_state == S_WAIT_WRAP) && (div_wrap || (r_cnt == c_TMO_LAST));

    // The grant is decided on the IDLE->ARB edge so ready and err are visible
    // during the ARB cycle itself; every other action lands on the edge that
    // leaves its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_prio      <= 1'b0;
            r_cap       <= c_DEF_RATIO;
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_err       <= 1'b0;
            r_div_en    <= 1'b0;
            r_div_ratio <= c_DEF_RATIO;
            r_div_load  <= 1'b0;
            r_busy      <= 1'b1;
            r_tmo       <= 1'b0;
        end else begin
            r_ready0   <= 1'b0;
            r_ready1   <= 1'b0;
            r_err      <= 1'b0;
            r_div_load <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_div_load  <= 1'b1;
                    r_div_ratio <= c_DEF_RATIO;
                    r_div_en    <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_SETTLE;
                end
                S_IDLE: begin
                    if (w_any) begin
                        r_ready0 <= ~w_win1;
                        r_ready1 <= w_win1;
                        r_cap    <= w_win_ratio;
                        r_err    <= w_win_bad;
                        r_prio   <= ~w_win1;
                        r_busy   <= 1'b1;
                        r_state  <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (r_err || (r_cap == r_div_ratio)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_WRAP;
                    end
                end
                S_WAIT_WRAP: begin
                    if (w_to_gate) begin
                        r_tmo   <= r_tmo | ~div_wrap;
                        r_state <= S_GATE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_GATE: begin
                    r_div_en    <= 1'b0;
                    r_div_ratio <= r_cap;
                    r_div_load  <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= S_ENABLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_ENABLE: begin
                    r_div_en <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

`ifdef CLK_DIV_SCHED_STATS_EN
    logic [15:0] r_reconfig_cnt;
    logic [7:0]  r_reject_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reconfig_cnt <= '0;
            r_reject_cnt   <= '0;
        end else begin
            if (w_to_gate && (r_reconfig_cnt != 16'hFFFF)) begin
                r_reconfig_cnt <= r_reconfig_cnt + 16'd1;
            end
            if (w_grant && w_win_bad && (r_reject_cnt != 8'hFF)) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
        end
    end

    assign reconfig_cnt = r_reconfig_cnt;
    assign reject_cnt   = r_reject_cnt;
`endif

    assign req0_ready = r_ready0;
    assign req1_ready = r_ready1;
    assign div_en     = r_div_en;
    assign div_ratio  = r_div_ratio;
    assign div_load   = r_div_load;
    assign busy       = r_busy;
    assign err        = r_err;
    assign tmo        = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Brief    : Directed self-checking bench for clk_div_sched.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_ratio;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_ratio;
    logic       req1_ready;
    logic       div_wrap;
    logic       div_en;
    logic [3:0] div_ratio;
    logic       div_load;
    logic       busy;
    logic       err;
    logic       tmo;
`ifdef CLK_DIV_SCHED_STATS_EN
    logic [15:0] reconfig_cnt;
    logic [7:0]  reject_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    clk_div_sched #(
        .RATIO_W    (4),
        .DEF_RATIO  (5),
        .SETTLE_CYC (4),
        .WRAP_TMO   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ratio   (req0_ratio),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_ratio   (req1_ratio),
        .req1_ready   (req1_ready),
        .div_wrap     (div_wrap),
        .div_en       (div_en),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .busy         (busy),
        .err          (err),
`ifdef CLK_DIV_SCHED_STATS_EN
        .reconfig_cnt (reconfig_cnt),
        .reject_cnt   (reject_cnt),
`endif
        .tmo          (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // div_en must never be high while the divider is being loaded
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_vec++;
            assert (!(div_en && div_load)) else begin
                n_miss++;
                $error("FAIL en_load_overlap: observed en=%0b load=%0b expected not both 1", div_en, div_load);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(req0_ready || req1_ready) && (k < 40));
        chk("grant_seen", 32'(req0_ready | req1_ready), 32'd1);
    endtask

    // Accepted request: W cycles in WAIT_WRAP, load two cycles after the last
    // of them, div_en back high five cycles after the load.
    task automatic reconfig(input int port, input logic [3:0] ratio, input int w,
                            input bit wrap, input bit exp_tmo,
                            input bit rearm, input logic [3:0] rearm_ratio);
        wait_grant();
        chk("ready0_arb", 32'(req0_ready), 32'(port == 0));
        chk("ready1_arb", 32'(req1_ready), 32'(port == 1));
        chk("err_arb", 32'(err), 32'd0);
        chk("busy_arb", 32'(busy), 32'd1);
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
        for (int k = 1; k <= w; k++) begin
            step();
            if (k == 1) begin
                chk("ready_once", 32'(req0_ready | req1_ready), 32'd0);
                if (rearm) begin
                    if (port == 0) begin req0_valid = 1'b1; req0_ratio = rearm_ratio; end
                    else           begin req1_valid = 1'b1; req1_ratio = rearm_ratio; end
                end
            end
            if (k == w && exp_tmo) chk("tmo_early", 32'(tmo), 32'd0);
            if (k == w && wrap) div_wrap = 1'b1;
        end
        step();
        div_wrap = 1'b0;
        chk("tmo_gate", 32'(tmo), 32'(exp_tmo));
        chk("load_pre", 32'(div_load), 32'd0);
        step();
        chk("load_pulse", 32'(div_load), 32'd1);
        chk("ratio_load", 32'(div_ratio), 32'(ratio));
        chk("en_gated", 32'(div_en), 32'd0);
        step();
        chk("load_end", 32'(div_load), 32'd0);
        step();
        step();
        step();
        chk("en_settle", 32'(div_en), 32'd0);
        step();
        chk("en_high", 32'(div_en), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("ratio_kept", 32'(div_ratio), 32'(ratio));
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_ratio = 4'd0;
        req1_valid = 1'b0;
        req1_ratio = 4'd0;
        div_wrap   = 1'b0;
        repeat (3) step();

        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_en", 32'(div_en), 32'd0);
        chk("rst_ratio", 32'(div_ratio), 32'd5);
        chk("rst_load", 32'(div_load), 32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("rst_err_tmo", 32'({err, tmo}), 32'd0);
        rst = 1'b0;
        step();
        chk("init_load", 32'(div_load), 32'd1);
        chk("init_ratio", 32'(div_ratio), 32'd5);
        chk("init_en", 32'(div_en), 32'd0);
        step();
        chk("init_load_end", 32'(div_load), 32'd0);
        step();
        step();
        step();
        chk("init_en_low", 32'(div_en), 32'd0);
        chk("init_busy", 32'(busy), 32'd1);
        step();
        chk("init_en_high", 32'(div_en), 32'd1);
        chk("init_idle", 32'(busy), 32'd0);

        // Tie after reset goes to req0; req1 waits and is served next
        req0_valid = 1'b1; req0_ratio = 4'd3;
        req1_valid = 1'b1; req1_ratio = 4'd9;
        reconfig(0, 4'd3, 2, 1'b1, 1'b0, 1'b0, 4'd0);
        reconfig(1, 4'd9, 2, 1'b1, 1'b0, 1'b0, 4'd0);

        // A stray wrap while idle must not be remembered
        div_wrap = 1'b1;
        step();
        div_wrap = 1'b0;
        chk("wrap_idle", 32'(busy), 32'd0);
        req0_valid = 1'b1; req0_ratio = 4'd7;
        req1_valid = 1'b1; req1_ratio = 4'd4;
        reconfig(0, 4'd7, 3, 1'b1, 1'b0, 1'b1, 4'd12);
        reconfig(1, 4'd4, 2, 1'b1, 1'b0, 1'b0, 4'd0);
        reconfig(0, 4'd12, 2, 1'b1, 1'b0, 1'b0, 4'd0);

        // Rejected ratio, then a ratio equal to the current one
        req1_valid = 1'b1; req1_ratio = 4'd1;
        wait_grant();
        chk("rej_ready1", 32'(req1_ready), 32'd1);
        chk("rej_ready0", 32'(req0_ready), 32'd0);
        chk("rej_err", 32'(err), 32'd1);
        req1_valid = 1'b0;
        step();
        chk("rej_err_end", 32'(err), 32'd0);
        chk("rej_idle", 32'(busy), 32'd0);
        chk("rej_noload", 32'(div_load), 32'd0);
        step();
        chk("rej_noload2", 32'(div_load), 32'd0);
        chk("rej_ratio", 32'(div_ratio), 32'd12);
        chk("rej_en", 32'(div_en), 32'd1);

        req1_valid = 1'b1; req1_ratio = 4'd12;
        wait_grant();
        chk("eq_ready1", 32'(req1_ready), 32'd1);
        chk("eq_err", 32'(err), 32'd0);
        req1_valid = 1'b0;
        step();
        chk("eq_idle", 32'(busy), 32'd0);
        chk("eq_noload", 32'(div_load), 32'd0);
        step();
        chk("eq_noload2", 32'(div_load), 32'd0);
        chk("eq_ratio", 32'(div_ratio), 32'd12);

        // Smallest legal ratio with the shortest wrap wait
        req1_valid = 1'b1; req1_ratio = 4'd2;
        reconfig(1, 4'd2, 1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Wrap on the last counted cycle beats the timeout; no wrap forces it
        req1_valid = 1'b1; req1_ratio = 4'd8;
        reconfig(1, 4'd8, 64, 1'b1, 1'b0, 1'b0, 4'd0);
        req0_valid = 1'b1; req0_ratio = 4'd6;
        reconfig(0, 4'd6, 64, 1'b0, 1'b1, 1'b0, 4'd0);
        step();
        chk("tmo_sticky", 32'(tmo), 32'd1);

        // Reset in the middle of SETTLE, with a request pending
        req1_valid = 1'b1; req1_ratio = 4'd10;
        wait_grant();
        chk("rs_ready1", 32'(req1_ready), 32'd1);
        req1_valid = 1'b0;
        step();
        div_wrap = 1'b1;
        step();
        div_wrap = 1'b0;
        step();
        chk("rs_load", 32'(div_load), 32'd1);
        chk("rs_ratio10", 32'(div_ratio), 32'd10);
        step();
`ifdef CLK_DIV_SCHED_STATS_EN
        chk("stat_reconfig", 32'(reconfig_cnt), 32'd9);
        chk("stat_reject", 32'(reject_cnt), 32'd1);
`endif
        rst = 1'b1;
        req0_valid = 1'b1; req0_ratio = 4'd8;
        step();
        chk("rs_en", 32'(div_en), 32'd0);
        chk("rs_ratio", 32'(div_ratio), 32'd5);
        chk("rs_load0", 32'(div_load), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_tmo", 32'(tmo), 32'd0);
        chk("rs_ready0", 32'(req0_ready), 32'd0);
`ifdef CLK_DIV_SCHED_STATS_EN
        chk("rs_stat_reconfig", 32'(reconfig_cnt), 32'd0);
        chk("rs_stat_reject", 32'(reject_cnt), 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("rs_init_load", 32'(div_load), 32'd1);
        chk("rs_init_ratio", 32'(div_ratio), 32'd5);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rs_settle_en", 32'(div_en), 32'd0);
            chk("rs_no_ready", 32'(req0_ready), 32'd0);
        end
        step();
        chk("rs_en_high", 32'(div_en), 32'd1);
        chk("rs_idle", 32'(busy), 32'd0);
        req0_valid = 1'b0;
        step();
        chk("rs_withdrawn", 32'(req0_ready), 32'd0);
        chk("rs_withdrawn_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
